// File: rtl/dfe_tune_ctrl.sv
// dfe_tune_ctrl: retune sequencer for the I/Q front end. Accepts a new NCO
// phase increment over cfg_req/cfg_ack and applies it on a CIC output boundary.
// It then blanks the FIR valids until old-frequency samples have flushed, and
// finally reports lock.
// Ports: clk, rst (async, active high); cfg_req/cfg_phi/cfg_ack/cfg_busy are
//   the host side; cic_vld is the alignment strobe; phi_inc drives the NCO;
//   sin/cos_vld_in are gated onto sin/cos_vld_out; locked, retune_cnt and
//   err_timeout are status outputs.
// Optional macro DFE_TUNE_TIMEOUT_EN: forces the apply after TIMEOUT cycles
//   in ALIGN and flags it on err_timeout.
module dfe_tune_ctrl #(
    parameter int unsigned          PHI_WIDTH  = 32,
    parameter logic [PHI_WIDTH-1:0] PHI_RESET  = '0,
    parameter int unsigned          SETTLE_OUT = 16,
    parameter int unsigned          TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_req,
    input  logic [PHI_WIDTH-1:0] cfg_phi,
    output logic                 cfg_ack,
    output logic                 cfg_busy,
    input  logic                 cic_vld,
    output logic [PHI_WIDTH-1:0] phi_inc,
    input  logic                 sin_vld_in,
    input  logic                 cos_vld_in,
    output logic                 sin_vld_out,
    output logic                 cos_vld_out,
    output logic                 locked,
    output logic [7:0]           retune_cnt,
    output logic                 err_timeout
);

    localparam int unsigned CW = $clog2(SETTLE_OUT + 1);

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_ALIGN,
        ST_SETTLE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        settle_cnt;
    logic [PHI_WIDTH-1:0] shadow;
    logic                 post_reset;
    logic                 accept;
    logic                 apply;
    logic                 settle_done;
    logic                 tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        apply       = 1'b0;
        settle_done = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (cfg_req) begin
                    accept  = 1'b1;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (cic_vld || tmo_hit) begin
                    apply   = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sin_vld_in && settle_cnt == CW'(1)) begin
                    settle_done = 1'b1;
                    state_d     = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phi_inc    <= PHI_RESET;
            shadow     <= '0;
            cfg_ack    <= 1'b0;
            settle_cnt <= CW'(SETTLE_OUT);
            retune_cnt <= 8'd0;
            post_reset <= 1'b1;
        end else begin
            cfg_ack <= accept;
            if (accept) begin
                shadow <= cfg_phi;
            end
            if (apply) begin
                phi_inc    <= shadow;
                settle_cnt <= CW'(SETTLE_OUT);
            end else if (state_q == ST_SETTLE && sin_vld_in) begin
                settle_cnt <= settle_cnt - CW'(1);
            end
            // The settle that follows reset is not a retune.
            if (settle_done) begin
                post_reset <= 1'b0;
                if (!post_reset) begin
                    retune_cnt <= retune_cnt + 8'd1;
                end
            end
        end
    end

`ifdef DFE_TUNE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // tmo_cnt is 0 on the ALIGN entry cycle, so the hit lands on the
    // TIMEOUT-th ALIGN cycle.
    assign tmo_hit = (state_q == ST_ALIGN) && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if (state_q == ST_ALIGN && !apply) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (apply && !cic_vld) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign locked      = (state_q == ST_LOCKED);
    assign cfg_busy    = (state_q != ST_LOCKED);
    assign sin_vld_out = sin_vld_in & (state_q != ST_SETTLE);
    assign cos_vld_out = cos_vld_in & (state_q != ST_SETTLE);

endmodule

// File: tb/tb_dfe_tune_ctrl.sv
// tb_dfe_tune_ctrl: scenario tasks plus a randomized run for dfe_tune_ctrl,
// checked every cycle against a behavioural model of the retune sequence.
module tb_dfe_tune_ctrl;

    localparam int unsigned    SETTLE_OUT = 4;
    localparam int unsigned    TIMEOUT    = 16;
    localparam logic [31:0]    PHI_RESET  = 32'h0000_0100;
`ifdef DFE_TUNE_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [31:0] cfg_phi;
    logic        cfg_ack;
    logic        cfg_busy;
    logic        cic_vld;
    logic [31:0] phi_inc;
    logic        sin_vld_in;
    logic        cos_vld_in;
    logic        sin_vld_out;
    logic        cos_vld_out;
    logic        locked;
    logic [7:0]  retune_cnt;
    logic        err_timeout;

    int vecs = 0;
    int errs = 0;

    dfe_tune_ctrl #(
        .PHI_WIDTH (32),
        .PHI_RESET (PHI_RESET),
        .SETTLE_OUT(SETTLE_OUT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_req    (cfg_req),
        .cfg_phi    (cfg_phi),
        .cfg_ack    (cfg_ack),
        .cfg_busy   (cfg_busy),
        .cic_vld    (cic_vld),
        .phi_inc    (phi_inc),
        .sin_vld_in (sin_vld_in),
        .cos_vld_in (cos_vld_in),
        .sin_vld_out(sin_vld_out),
        .cos_vld_out(cos_vld_out),
        .locked     (locked),
        .retune_cnt (retune_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    wire [45:0] dut_vec = {cfg_ack, cfg_busy, phi_inc, sin_vld_out,
                           cos_vld_out, locked, retune_cnt, err_timeout};

    // Behavioural model: "blanks left" while settling, "waiting" for a
    // CIC boundary, and a plain integer count of completed retunes.
    bit          m_settling;
    bit          m_waiting;
    bit          m_first;
    bit          m_ack;
    bit          m_err;
    int          m_blank;
    int          m_wait;
    int          m_retunes;
    logic [31:0] m_phi;
    logic [31:0] m_shadow;

    function automatic void model_reset();
        m_settling = 1'b1;
        m_waiting  = 1'b0;
        m_first    = 1'b1;
        m_ack      = 1'b0;
        m_err      = 1'b0;
        m_blank    = SETTLE_OUT;
        m_wait     = 0;
        m_retunes  = 0;
        m_phi      = PHI_RESET;
        m_shadow   = '0;
    endfunction

    function automatic void model_step();
        m_ack = 1'b0;
        if (m_settling) begin
            if (sin_vld_in) begin
                m_blank = m_blank - 1;
                if (m_blank == 0) begin
                    m_settling = 1'b0;
                    if (!m_first) m_retunes = m_retunes + 1;
                    m_first = 1'b0;
                end
            end
        end else if (m_waiting) begin
            if (cic_vld || (TMO_ON && m_wait == TIMEOUT - 1)) begin
                m_phi      = m_shadow;
                m_waiting  = 1'b0;
                m_settling = 1'b1;
                m_blank    = SETTLE_OUT;
                if (!cic_vld) m_err = 1'b1;
            end else begin
                m_wait = m_wait + 1;
            end
        end else if (cfg_req) begin
            m_shadow  = cfg_phi;
            m_ack     = 1'b1;
            m_waiting = 1'b1;
            m_wait    = 0;
            m_err     = 1'b0;
        end
    endfunction

    function automatic logic [45:0] exp_vec();
        logic lk;
        logic [7:0] rc;
        lk = !m_settling && !m_waiting;
        rc = 8'(m_retunes % 256);
        return {m_ack, !lk, m_phi, sin_vld_in & !m_settling,
                cos_vld_in & !m_settling, lk, rc, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic run_until_locked(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (locked) begin
                ok = 1'b1;
                break;
            end
            cfg_req    = 1'b0;
            cic_vld    = 1'($urandom_range(0, 1));
            sin_vld_in = 1'($urandom_range(0, 1));
            cos_vld_in = 1'($urandom_range(0, 1));
            #1;
            vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++;
                $display("FAIL settle_run t=%0t dut=%h exp=%h",
                         $time, dut_vec, exp_vec());
            end
            tick();
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL lock_wait: locked=%b after %0d cycles, want 1",
                     locked, budget);
        end
        cic_vld    = 1'b0;
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
    endtask

    task automatic test_reset();
        int passed;
        rst        = 1'b1;
        cfg_req    = 1'b0;
        cfg_phi    = '0;
        cic_vld    = 1'b0;
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL reset_vec dut=%h exp=%h", dut_vec, exp_vec());
        end
        vecs++;
        if (phi_inc !== PHI_RESET || retune_cnt !== 8'd0 || locked !== 1'b0) begin
            errs++;
            $display("FAIL reset_vals phi=%h cnt=%0d lk=%b want %h 0 0",
                     phi_inc, retune_cnt, locked, PHI_RESET);
        end
        @(negedge clk);
        rst    = 1'b0;
        passed = 0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 40; c++) begin
                sin_vld_in = (c == 0);
                cos_vld_in = (c == 0);
                #1;
                vecs++;
                if (dut_vec !== exp_vec()) begin
                    errs++;
                    $display("FAIL reset_settle t=%0t dut=%h exp=%h",
                             $time, dut_vec, exp_vec());
                end
                if (c == 0 && sin_vld_out) passed++;
                tick();
                if (c == 0 && (k == 2 || k == 3)) begin
                    vecs++;
                    if (locked !== (k == 3)) begin
                        errs++;
                        $display("FAIL reset_lock_edge k=%0d locked=%b want %b",
                                 k, locked, (k == 3));
                    end
                end
            end
        end
        vecs++;
        if (passed !== 2 || phi_inc !== PHI_RESET || retune_cnt !== 8'd0) begin
            errs++;
            $display("FAIL reset_pass passed=%0d phi=%h cnt=%0d want 2 %h 0",
                     passed, phi_inc, retune_cnt, PHI_RESET);
        end
    endtask

    task automatic test_retune();
        cfg_req    = 1'b1;
        cfg_phi    = 32'h0A3D70A4;
        sin_vld_in = 1'b1;
        cos_vld_in = 1'b1;
        #1;
        vecs++;
        if (dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL retune_req dut=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        cfg_req = 1'b0;
        cfg_phi = $urandom;
        #1;
        vecs++;
        if (cfg_ack !== 1'b1 || sin_vld_out !== 1'b1 || cfg_busy !== 1'b1) begin
            errs++;
            $display("FAIL retune_ack ack=%b vld=%b busy=%b want 1 1 1",
                     cfg_ack, sin_vld_out, cfg_busy);
        end
        tick();
        for (int i = 2; i <= 8; i++) begin
            cic_vld    = (i == 8);
            sin_vld_in = 1'($urandom_range(0, 1));
            cos_vld_in = sin_vld_in;
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || phi_inc !== PHI_RESET) begin
                errs++;
                $display("FAIL retune_align i=%0d dut=%h exp=%h",
                         i, dut_vec, exp_vec());
            end
            tick();
        end
        cic_vld = 1'b0;
        vecs++;
        if (phi_inc !== 32'h0A3D70A4) begin
            errs++;
            $display("FAIL retune_apply phi=%h want 0a3d70a4", phi_inc);
        end
        for (int i = 0; i < 8; i++) begin
            sin_vld_in = (i % 2 == 0);
            cos_vld_in = sin_vld_in;
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || sin_vld_out !== 1'b0) begin
                errs++;
                $display("FAIL retune_blank i=%0d dut=%h exp=%h",
                         i, dut_vec, exp_vec());
            end
            tick();
        end
        sin_vld_in = 1'b1;
        #1;
        vecs++;
        if (locked !== 1'b1 || retune_cnt !== 8'd1 || sin_vld_out !== 1'b1) begin
            errs++;
            $display("FAIL retune_lock lk=%b cnt=%0d vld=%b want 1 1 1",
                     locked, retune_cnt, sin_vld_out);
        end
        tick();
        sin_vld_in = 1'b0;
    endtask

    task automatic test_held_req();
        cfg_req    = 1'b1;
        cfg_phi    = 32'h0000_5555;
        cic_vld    = 1'b0;
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
        #1;
        tick();
        cfg_phi = 32'h1;
        cic_vld = 1'b1;
        #1;
        vecs++;
        if (dut_vec !== exp_vec() || cfg_ack !== 1'b1) begin
            errs++;
            $display("FAIL held_ack1 dut=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        cic_vld    = 1'b0;
        sin_vld_in = 1'b1;
        cos_vld_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || cfg_ack !== 1'b0 ||
                phi_inc !== 32'h5555) begin
                errs++;
                $display("FAIL held_busy i=%0d dut=%h exp=%h",
                         i, dut_vec, exp_vec());
            end
            tick();
        end
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
        #1;
        vecs++;
        if (locked !== 1'b1 || cfg_ack !== 1'b0) begin
            errs++;
            $display("FAIL held_lockcyc lk=%b ack=%b want 1 0", locked, cfg_ack);
        end
        tick();
        cic_vld = 1'b1;
        #1;
        vecs++;
        if (dut_vec !== exp_vec() || cfg_ack !== 1'b1) begin
            errs++;
            $display("FAIL held_ack2 dut=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        cfg_req = 1'b0;
        cic_vld = 1'b0;
        #1;
        vecs++;
        if (phi_inc !== 32'h1) begin
            errs++;
            $display("FAIL held_apply phi=%h want 00000001", phi_inc);
        end
        tick();
        run_until_locked(200);
        vecs++;
        if (retune_cnt !== 8'd3) begin
            errs++;
            $display("FAIL held_count cnt=%0d want 3", retune_cnt);
        end
    endtask

    task automatic test_align_entry();
        logic [31:0] old_phi;
        logic [31:0] new_phi;
        old_phi = m_phi;
        new_phi = $urandom;
        cfg_req = 1'b1;
        cfg_phi = new_phi;
        #1;
        tick();
        cfg_req    = 1'b0;
        cic_vld    = 1'b1;
        sin_vld_in = 1'b1;
        cos_vld_in = 1'b1;
        #1;
        vecs++;
        if (sin_vld_out !== 1'b1 || cos_vld_out !== 1'b1 || phi_inc !== old_phi) begin
            errs++;
            $display("FAIL entry_pass vld=%b%b phi=%h want 11 %h",
                     sin_vld_out, cos_vld_out, phi_inc, old_phi);
        end
        tick();
        cic_vld    = 1'b0;
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
        #1;
        vecs++;
        if (phi_inc !== new_phi || dut_vec !== exp_vec()) begin
            errs++;
            $display("FAIL entry_apply phi=%h want %h", phi_inc, new_phi);
        end
        tick();
        run_until_locked(200);
    endtask

    task automatic test_timeout();
        logic [31:0] old_phi;
        logic [31:0] new_phi;
        logic [31:0] want_phi;
        old_phi = m_phi;
        new_phi = $urandom;
        cfg_req = 1'b1;
        cfg_phi = new_phi;
        cic_vld = 1'b0;
        #1;
        tick();
        cfg_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sin_vld_in = 1'b0;
            cos_vld_in = 1'b0;
            want_phi   = (TMO_ON && i >= 16) ? new_phi : old_phi;
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || phi_inc !== want_phi ||
                err_timeout !== (TMO_ON && i >= 16) || locked !== 1'b0) begin
                errs++;
                $display("FAIL timeout i=%0d phi=%h err=%b want %h %b",
                         i, phi_inc, err_timeout, want_phi, (TMO_ON && i >= 16));
            end
            tick();
        end
        if (!TMO_ON) begin
            cic_vld = 1'b1;
            #1;
            tick();
        end
        run_until_locked(200);
        vecs++;
        if (err_timeout !== TMO_ON) begin
            errs++;
            $display("FAIL timeout_sticky err=%b want %b", err_timeout, TMO_ON);
        end
        cfg_req = 1'b1;
        cfg_phi = $urandom;
        #1;
        tick();
        cfg_req = 1'b0;
        #1;
        vecs++;
        if (err_timeout !== 1'b0 || cfg_ack !== 1'b1) begin
            errs++;
            $display("FAIL timeout_clear err=%b ack=%b want 0 1",
                     err_timeout, cfg_ack);
        end
        cic_vld = 1'b1;
        tick();
        run_until_locked(200);
    endtask

    task automatic test_rst_mid();
        int blanked;
        cfg_req = 1'b1;
        cfg_phi = $urandom;
        #1;
        tick();
        cfg_req = 1'b0;
        cic_vld = 1'b1;
        #1;
        tick();
        cic_vld    = 1'b0;
        sin_vld_in = 1'b1;
        cos_vld_in = 1'b1;
        #1;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vecs++;
        if (dut_vec !== exp_vec() || phi_inc !== PHI_RESET ||
            retune_cnt !== 8'd0 || cfg_busy !== 1'b1) begin
            errs++;
            $display("FAIL rst_async dut=%h exp=%h", dut_vec, exp_vec());
        end
        tick();
        rst     = 1'b0;
        blanked = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            vecs++;
            if (dut_vec !== exp_vec()) begin
                errs++;
                $display("FAIL rst_settle i=%0d dut=%h exp=%h",
                         i, dut_vec, exp_vec());
            end
            if (!sin_vld_out) blanked++;
            tick();
        end
        vecs++;
        if (blanked !== SETTLE_OUT || locked !== 1'b1) begin
            errs++;
            $display("FAIL rst_blank blanked=%0d lk=%b want %0d 1",
                     blanked, locked, SETTLE_OUT);
        end
        sin_vld_in = 1'b0;
        cos_vld_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit prev_ack;
        prev_ack   = 1'b0;
        cfg_req    = 1'b1;
        cic_vld    = 1'b1;
        sin_vld_in = 1'b1;
        cos_vld_in = 1'b1;
        for (int i = 0; i < 256 * 6; i++) begin
            cfg_phi = $urandom;
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || (cfg_ack && prev_ack)) begin
                errs++;
                $display("FAIL b2b i=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
            prev_ack = cfg_ack;
            if (i == 255 * 6) begin
                vecs++;
                if (retune_cnt !== 8'd255) begin
                    errs++;
                    $display("FAIL b2b_255 cnt=%0d want 255", retune_cnt);
                end
            end
            tick();
        end
        #1;
        vecs++;
        if (retune_cnt !== 8'd0 || locked !== 1'b1) begin
            errs++;
            $display("FAIL b2b_wrap cnt=%0d lk=%b want 0 1", retune_cnt, locked);
        end
        cfg_req = 1'b0;
        tick();
        run_until_locked(200);
    endtask

    task automatic test_random();
        bit prev_ack;
        prev_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cfg_req    = ($urandom_range(0, 9) < 3);
            cfg_phi    = $urandom;
            cic_vld    = ($urandom_range(0, 3) == 0);
            sin_vld_in = 1'($urandom_range(0, 1));
            cos_vld_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            #1;
            vecs++;
            if (dut_vec !== exp_vec() || (cfg_ack && prev_ack)) begin
                errs++;
                $display("FAIL random i=%0d dut=%h exp=%h", i, dut_vec, exp_vec());
            end
            prev_ack = cfg_ack;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_retune();
        test_held_req();
        test_align_entry();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
